// File: rtl/psg_bus_interface_if.sv
// Host write port and register-file write channel of the PSG front end.
// The master side is the host (and the observer of the downstream channel).
// The slave side is the bus interface block itself.
interface psg_bus_interface_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]       bus_data;
  logic             bus_ce_n;
  logic             bus_we_n;
  logic             bus_ready;
  logic             wr_valid;
  logic [7:0]       wr_data;
  logic [LVL_W-1:0] fifo_level;
  logic             overflow;

  modport master (
    output bus_data,
    output bus_ce_n,
    output bus_we_n,
    input  bus_ready,
    input  wr_valid,
    input  wr_data,
    input  fifo_level,
    input  overflow
  );

  modport slave (
    input  bus_data,
    input  bus_ce_n,
    input  bus_we_n,
    output bus_ready,
    output wr_valid,
    output wr_data,
    output fifo_level,
    output overflow
  );
endinterface

// File: rtl/psg_bus_interface.sv
// SN76489-style host write port.
// Synchronises the asynchronous /CE,/WE strobe and data byte, and detects one
// accept per strobe low pulse. Accepted bytes are buffered in a small FIFO and
// released downstream as single-cycle write pulses, at least WRITE_INTERVAL
// clocks apart.
module psg_bus_interface #(
  parameter int FIFO_DEPTH     = 4,
  parameter int WRITE_INTERVAL = 32,
  parameter int SYNC_STAGES    = 2
) (
  input  logic               clk,
  input  logic               reset,
  psg_bus_interface_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = (WRITE_INTERVAL > 1) ? $clog2(WRITE_INTERVAL) : 1;
  localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(WRITE_INTERVAL - 1);

  // synchroniser / edge detect
  logic                   w_strb_n;
  logic [SYNC_STAGES-1:0] r_strb_sync;
  logic [7:0]             r_data_sync [SYNC_STAGES];
  // bit k is set once stage k (bit SYNC_STAGES: r_strb_prev) holds a
  // sample taken after reset release
  logic [SYNC_STAGES:0]   r_post_rst;
  logic                   r_strb_prev;
  logic                   w_fall;
  logic                   r_accept;
  logic [7:0]             r_accept_data;

  // FIFO and pacing
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [LVL_W-1:0] r_level;
  logic [LVL_W-1:0] w_level_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;

  // registered outputs
  logic       r_wr_valid;
  logic [7:0] r_wr_data;
  logic       r_overflow;
  logic       r_bus_ready;

  assign w_strb_n = bus.bus_ce_n | bus.bus_we_n;

  // Shift strobe and data through the synchroniser and remember the previous synchronised strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      r_strb_sync <= '1;
      r_post_rst  <= '0;
      r_strb_prev <= 1'b1;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_data_sync[i] <= '0;
      end
    end else begin
      r_strb_sync    <= {r_strb_sync[SYNC_STAGES-2:0], w_strb_n};
      r_post_rst     <= {r_post_rst[SYNC_STAGES-1:0], 1'b1};
      r_strb_prev    <= r_strb_sync[SYNC_STAGES-1];
      r_data_sync[0] <= bus.bus_data;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_data_sync[i] <= r_data_sync[i-1];
      end
    end
  end

  // A fall only counts between two samples taken after reset release, so a
  // strobe held low through reset needs a fresh high-to-low transition.
  assign w_fall = r_post_rst[SYNC_STAGES] & r_strb_prev & ~r_strb_sync[SYNC_STAGES-1];

  // Register the accept event together with its aligned data byte
  always_ff @(posedge clk) begin
    if (reset) begin
      r_accept      <= 1'b0;
      r_accept_data <= '0;
    end else begin
      r_accept      <= w_fall;
      r_accept_data <= r_data_sync[SYNC_STAGES-1];
    end
  end

  // Decide pop/push/drop for this cycle and the resulting occupancy
  always_comb begin
    w_full       = (r_level == LVL_FULL);
    w_pop        = (r_cnt == '0) && (r_level != '0);
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    w_push       = r_accept && (!w_full || w_pop);
    w_drop       = r_accept && w_full && !w_pop;
    w_level_next = r_level;
    if (w_push && !w_pop) begin
      w_level_next = r_level + LVL_W'(1);
    end else if (w_pop && !w_push) begin
      w_level_next = r_level - LVL_W'(1);
    end
  end

  // FIFO storage: write-only port at the tail, no reset on the array
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_tail] <= r_accept_data;
    end
  end

  // Pointers, occupancy, interval counter and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_level     <= '0;
      r_cnt       <= '0;
      r_wr_valid  <= 1'b0;
      r_wr_data   <= '0;
      r_overflow  <= 1'b0;
      r_bus_ready <= 1'b0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head    <= r_head + PTR_W'(1);
        r_wr_data <= r_mem[r_head];
        r_cnt     <= CNT_RELOAD;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      r_level     <= w_level_next;
      r_wr_valid  <= w_pop;
      r_overflow  <= w_drop;
      r_bus_ready <= (w_level_next < LVL_FULL);
    end
  end

  assign bus.bus_ready  = r_bus_ready;
  assign bus.wr_valid   = r_wr_valid;
  assign bus.wr_data    = r_wr_data;
  assign bus.fifo_level = r_level;
  assign bus.overflow   = r_overflow;
endmodule

// File: doc/psg_bus_interface.md
Name: psg_bus_interface

Overview:
- Host-side front end for the PSG register file, emulating the SN76489 /CE, /WE, READY write port.
- Synchronises the asynchronous host strobe and captures the data byte.
- Buffers captured bytes in a small FIFO and issues them downstream as single-cycle write pulses, spaced at least WRITE_INTERVAL clocks apart.
- The register-decode stage downstream acts only on cycles where wr_valid is high.

Parameters:
FIFO_DEPTH, 4, number of buffered host bytes (power of two, >=2)
WRITE_INTERVAL, 32, minimum clocks between consecutive wr_valid pulses (>=1)
SYNC_STAGES, 2, flip-flop stages on bus_ce_n/bus_we_n/bus_data (>=2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
bus_data  input  8  host data byte (asynchronous)
bus_ce_n  input  1  host chip enable, active low (asynchronous)
bus_we_n  input  1  host write enable, active low (asynchronous)
bus_ready  output  1  high when a new host write can be buffered
wr_valid  output  1  one-cycle write pulse to register file
wr_data  output  8  byte for register file, valid when wr_valid=1
fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
overflow  output  1  one-cycle pulse when a host write is dropped

Behaviour:
- Interface: reset is synchronous and active-high; clock is clk. All state is updated on posedge clk.
- Reset values:
  - bus_ready=0, wr_valid=0, wr_data=0, fifo_level=0, overflow=0.
  - Interval counter=0.
  - Synchroniser strobe flops = 1 (inactive), so no edge is detected on reset release.
  - Data sync flops = 0.
- Strobe: strb_n = bus_ce_n | bus_we_n. strb_n passes through SYNC_STAGES flops. bus_data passes through the same number of flops so it stays aligned with the strobe.
- Accept event: the synchronised strb_n was 1 in the previous cycle and is 0 now (falling edge).
  - Exactly one accept per low pulse, however long the pulse is held.
  - Host must hold bus_data stable from strobe fall for at least SYNC_STAGES+1 clocks.
- Push: on an accept event, the synchronised data byte is written to the FIFO tail.
  - Latency: an input strobe fall before clock edge 0 is visible in fifo_level after edge SYNC_STAGES+1.
- Pop rule: the FIFO pops when the interval counter is 0 and the FIFO is not empty. On the pop edge:
  - wr_valid=1 for exactly one cycle; wr_data = head byte.
  - Counter is loaded with WRITE_INTERVAL-1.
- Interval counter:
  - Decrements by 1 each cycle while non-zero; holds at 0.
  - After idle, the first byte issues on the cycle after it is pushed.
- wr_data holds its last value when wr_valid=0.
- Simultaneous push and pop:
  - Both occur; fifo_level is unchanged.
  - This also applies when the FIFO is full, so the write is accepted.
- Full (level==FIFO_DEPTH), accept event, no pop in the same cycle:
  - Byte is dropped and FIFO contents are unchanged.
  - overflow=1 for one cycle.
- Empty: no pop and wr_valid stays 0. The counter keeps decrementing to 0.
- bus_ready: registered, = (next fifo_level < FIFO_DEPTH). It is 1 from the first cycle after reset release while the FIFO is empty.
- Pointers wrap modulo FIFO_DEPTH. fifo_level ranges 0..FIFO_DEPTH inclusive.
- Reset mid-operation:
  - FIFO is flushed and all outputs return to reset values on the next edge.
  - A strobe held low through reset release is not accepted; a fresh 1→0 transition is required.
- Implementation: no combinational path from bus_* to any output; all outputs are registered.

Test Plan:
- Single write: reset, then drive bus_data=0x9F with ce_n=we_n=0 for 5 clocks -> exactly one wr_valid pulse with wr_data=0x9F, 4 clocks after the strobe-fall edge (SYNC_STAGES=2). fifo_level goes 0->1->0.
- Spacing: 3 host writes 0x80, 0x05, 0x90 issued 4 clocks apart -> wr_valid pulses at t, t+32, t+64 with bytes in order. No overflow.
- Overflow: 6 host writes 4 clocks apart, starting from idle -> writes 1-5 accepted (one pops immediately). The 6th sees fifo_level=4 with no pop, so overflow pulses once; bus_ready=0 while level=4. The 5 accepted bytes then drain in order at 32-clock spacing.
- Full push+pop: fill FIFO to 4 and align the next accept with the pop cycle (counter reaches 0) -> no overflow; fifo_level stays 4; the new byte emerges last.
- Held strobe: hold ce_n=we_n=0 for 200 clocks with data 0xE4 -> exactly one wr_valid (0xE4). Toggle we_n high for 3 clocks then low again -> a second pulse.
- Reset mid-drain: with 3 bytes buffered, assert reset for 1 cycle -> next cycle fifo_level=0, wr_valid=0, bus_ready=0. bus_ready=1 the following cycle. No stale bytes are ever emitted.
